// File: rtl/yoda_pkg.sv
// Shared types and constants for the cipher TX packer.
// The optional checksum framing is enabled by defining PACKER_CSUM_EN.
`ifndef ENCRYPTER_WIDTH
`define ENCRYPTER_WIDTH 16
`endif

package yoda_pkg;

  localparam int WORD_W               = `ENCRYPTER_WIDTH;
  localparam int BYTE_W               = 8;
  localparam int PACKER_DEPTH_DEFAULT = 4;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_ACK  = 1'b1
  } cap_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HI   = 2'd1,
    TX_LO   = 2'd2
`ifdef PACKER_CSUM_EN
    , TX_SUM = 2'd3
`endif
  } tx_state_t;

  function automatic logic [BYTE_W-1:0] hi_byte(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: BYTE_W];
  endfunction

  function automatic logic [BYTE_W-1:0] lo_byte(input logic [WORD_W-1:0] w);
    return w[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/cipher_tx_packer_fifo.sv
// Parameterised synchronous FIFO; a pop in the same cycle frees the slot for a push when full.
module packer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: storage has no reset; only the pointers and count define what is valid,
  // and leaving the array unreset lets it map onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/cipher_tx_packer.sv
// Captures Encrypter words via the dataRdyOut/cap handshake and serialises them MSB byte first.
// Define PACKER_CSUM_EN to append an XOR checksum byte after every FRAME_WORDS words.
module cipher_tx_packer
  import yoda_pkg::*;
#(
  parameter int DEPTH = PACKER_DEPTH_DEFAULT
`ifdef PACKER_CSUM_EN
  , parameter int FRAME_WORDS = 8
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_W-1:0]      cipherIn,
  input  logic                   cipherRdy,
  output logic                   cap,
  output logic [BYTE_W-1:0]      txData,
  output logic                   txValid,
  input  logic                   txReady,
  output logic [$clog2(DEPTH):0] fifoCount,
  output logic [2:0]             state
);

  cap_state_t        r_cap_state;
  logic              r_armed;
  logic              r_cap;
  tx_state_t         r_tx_state;
  logic [BYTE_W-1:0] r_lo;
  logic [BYTE_W-1:0] r_tx_data;
  logic              r_tx_valid;
`ifdef PACKER_CSUM_EN
  logic [BYTE_W-1:0] r_csum;
  logic [7:0]        r_word_cnt;
`endif

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [WORD_W-1:0] w_fifo_data;

  assign w_pop  = (r_tx_state == TX_IDLE) && !w_empty;
  assign w_push = (r_cap_state == CAP_IDLE) && r_armed && cipherRdy && (!w_full || w_pop);

  packer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (cipherIn),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifoCount)
  );

  // r_armed drops on capture and only returns once cipherRdy is seen low,
  // so one dataRdyOut assertion can never yield two captures.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap_state <= CAP_IDLE;
      r_armed     <= 1'b1;
      r_cap       <= 1'b1;
    end else begin
      case (r_cap_state)
        CAP_IDLE: begin
          if (w_push) begin
            r_cap_state <= CAP_ACK;
            r_cap       <= 1'b0;
            r_armed     <= 1'b0;
          end else if (!cipherRdy) begin
            r_armed <= 1'b1;
          end
        end
        CAP_ACK: begin
          r_cap_state <= CAP_IDLE;
          r_cap       <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_lo       <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
`ifdef PACKER_CSUM_EN
      r_csum     <= '0;
      r_word_cnt <= '0;
`endif
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_pop) begin
            r_lo       <= lo_byte(w_fifo_data);
            r_tx_data  <= hi_byte(w_fifo_data);
            r_tx_valid <= 1'b1;
            r_tx_state <= TX_HI;
          end
        end
        TX_HI: begin
          if (txReady) begin
            r_tx_data  <= r_lo;
            r_tx_state <= TX_LO;
`ifdef PACKER_CSUM_EN
            r_csum     <= r_csum ^ r_tx_data;
`endif
          end
        end
        TX_LO: begin
          if (txReady) begin
`ifdef PACKER_CSUM_EN
            r_csum <= r_csum ^ r_tx_data;
            if (r_word_cnt == 8'(FRAME_WORDS - 1)) begin
              r_tx_data  <= r_csum ^ r_tx_data;
              r_tx_state <= TX_SUM;
            end else begin
              r_word_cnt <= r_word_cnt + 8'd1;
              r_tx_valid <= 1'b0;
              r_tx_state <= TX_IDLE;
            end
`else
            r_tx_valid <= 1'b0;
            r_tx_state <= TX_IDLE;
`endif
          end
        end
`ifdef PACKER_CSUM_EN
        TX_SUM: begin
          if (txReady) begin
            r_tx_valid <= 1'b0;
            r_csum     <= '0;
            r_word_cnt <= '0;
            r_tx_state <= TX_IDLE;
          end
        end
`endif
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign cap     = r_cap;
  assign txData  = r_tx_data;
  assign txValid = r_tx_valid;
  assign state   = {r_cap_state, r_tx_state};

endmodule

// File: tb/tb_cipher_tx_packer.sv
// Directed bench for cipher_tx_packer; checksum framing is exercised when PACKER_CSUM_EN is defined.
module tb_cipher_tx_packer;

  localparam int DEPTH = 4;
`ifdef PACKER_CSUM_EN
  localparam int FRAME_WORDS = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cipherIn;
  logic        cipherRdy;
  logic        cap;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic [2:0]  fifoCount;
  logic [2:0]  state;

  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   low_cycles = 0;
  logic prev_cap = 1'b1;
  logic [7:0] got [$];
  logic [7:0] exp [$];
`ifdef PACKER_CSUM_EN
  logic [7:0] m_sum = 8'h00;
  int         m_cnt = 0;
`endif

  cipher_tx_packer #(
    .DEPTH (DEPTH)
`ifdef PACKER_CSUM_EN
    , .FRAME_WORDS (FRAME_WORDS)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cipherIn  (cipherIn),
    .cipherRdy (cipherRdy),
    .cap       (cap),
    .txData    (txData),
    .txValid   (txValid),
    .txReady   (txReady),
    .fifoCount (fifoCount),
    .state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: log a byte the coming edge will accept, then observe cap after it.
  task automatic cycle();
    if (txValid === 1'b1 && txReady === 1'b1 && reset === 1'b0) got.push_back(txData);
    @(negedge clk);
    if (cap === 1'b0) begin
      low_cycles++;
      if (prev_cap === 1'b1) pulses++;
    end
    prev_cap = cap;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic add_word(input logic [15:0] w);
    exp.push_back(w[15:8]);
    exp.push_back(w[7:0]);
`ifdef PACKER_CSUM_EN
    m_sum = m_sum ^ w[15:8] ^ w[7:0];
    m_cnt++;
    if (m_cnt == FRAME_WORDS) begin
      exp.push_back(m_sum);
      m_sum = 8'h00;
      m_cnt = 0;
    end
`endif
  endtask

  task automatic clear_model();
    got.delete();
    exp.delete();
`ifdef PACKER_CSUM_EN
    m_sum = 8'h00;
    m_cnt = 0;
`endif
  endtask

  task automatic wait_cap(input string tag, input int budget);
    int n = 0;
    while (cap !== 1'b0 && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 32'(cap), 32'd0);
  endtask

  task automatic send_word(input string tag, input logic [15:0] w);
    cipherIn  = w;
    cipherRdy = 1'b1;
    wait_cap(tag, 20);
    cipherRdy = 1'b0;
    run(2);
    add_word(w);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    got.delete();
    exp.delete();
  endtask

  initial begin
    reset     = 1'b1;
    cipherIn  = 16'h0000;
    cipherRdy = 1'b0;
    txReady   = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    check("rst_cap",   32'(cap),       32'd1);
    check("rst_valid", 32'(txValid),   32'd0);
    check("rst_data",  32'(txData),    32'd0);
    check("rst_count", 32'(fifoCount), 32'd0);
    check("rst_state", 32'(state),     32'd0);
    reset = 1'b0;
    run(2);
    check("idle_state", 32'(state),   32'd0);
    check("idle_valid", 32'(txValid), 32'd0);

    // 1: single word, latency and one-cycle cap pulse
    pulses = 0; low_cycles = 0;
    txReady   = 1'b1;
    cipherIn  = 16'hF0F0;
    cipherRdy = 1'b1;
    cycle();
    check("t1_cap_low",  32'(cap),       32'd0);
    check("t1_count1",   32'(fifoCount), 32'd1);
    check("t1_valid0",   32'(txValid),   32'd0);
    check("t1_state_ack", 32'(state),    32'd4);
    cipherRdy = 1'b0;
    cycle();
    check("t1_cap_high", 32'(cap),       32'd1);
    check("t1_valid1",   32'(txValid),   32'd1);
    check("t1_hi",       32'(txData),    32'hF0);
    check("t1_count0",   32'(fifoCount), 32'd0);
    check("t1_state_hi", 32'(state),     32'd1);
    add_word(16'hF0F0);
    run(5);
    check("t1_pulses",   32'(pulses),     32'd1);
    check("t1_low",      32'(low_cycles), 32'd1);
    check("t1_valid_end", 32'(txValid),   32'd0);
    check("t1_count_end", 32'(fifoCount), 32'd0);
    compare_stream("t1");

    // 2: back-pressure holds the high byte stable
    pulses = 0; low_cycles = 0;
    txReady = 1'b0;
    send_word("t2_cap", 16'hCCE3);
    repeat (10) begin
      check("t2_hold_valid", 32'(txValid), 32'd1);
      check("t2_hold_data",  32'(txData),  32'hCC);
      cycle();
    end
    txReady = 1'b1;
    run(6);
    check("t2_pulses", 32'(pulses), 32'd1);
    compare_stream("t2");

    // 3: fill FIFO (one word sits in the TX holding register), then a blocked word
    pulses = 0; low_cycles = 0;
    txReady = 1'b0;
    for (int w = 1; w <= 5; w++) send_word("t3_cap", 16'(w));
    check("t3_pulses5", 32'(pulses),    32'd5);
    check("t3_full",    32'(fifoCount), 32'd4);
    cipherIn  = 16'h0006;
    cipherRdy = 1'b1;
    run(8);
    check("t3_blocked_pulses", 32'(pulses),    32'd5);
    check("t3_blocked_cap",    32'(cap),       32'd1);
    check("t3_blocked_count",  32'(fifoCount), 32'd4);
    check("t3_blocked_state",  32'(state),     32'd1);
    txReady = 1'b1;
    wait_cap("t3_cap6", 20);
    cipherRdy = 1'b0;
    add_word(16'h0006);
    run(30);
    check("t3_pulses6", 32'(pulses),     32'd6);
    check("t3_low6",    32'(low_cycles), 32'd6);
    check("t3_count0",  32'(fifoCount),  32'd0);
    compare_stream("t3");

    // 4: cipherRdy stuck high yields one capture
    pulses = 0; low_cycles = 0;
    txReady   = 1'b1;
    cipherIn  = 16'hA55A;
    cipherRdy = 1'b1;
    run(6);
    cipherRdy = 1'b0;
    add_word(16'hA55A);
    run(6);
    check("t4_pulses", 32'(pulses),     32'd1);
    check("t4_low",    32'(low_cycles), 32'd1);
    check("t4_count",  32'(fifoCount),  32'd0);
    compare_stream("t4");

    // 5: asynchronous reset while in TX_LO with cap low and words queued
    txReady = 1'b0;
    send_word("t5_cap_a", 16'hBEEF);
    send_word("t5_cap_b", 16'h1111);
    txReady = 1'b1;
    cycle();
    txReady   = 1'b0;
    cipherIn  = 16'h2222;
    cipherRdy = 1'b1;
    cycle();
    check("t5_pre_cap",   32'(cap),       32'd0);
    check("t5_pre_state", 32'(state),     32'd6);
    check("t5_pre_count", 32'(fifoCount), 32'd2);
    check("t5_pre_data",  32'(txData),    32'hEF);
    #2 reset = 1'b1;
    #1;
    check("t5_async_cap",   32'(cap),       32'd1);
    check("t5_async_valid", 32'(txValid),   32'd0);
    check("t5_async_count", 32'(fifoCount), 32'd0);
    check("t5_async_data",  32'(txData),    32'd0);
    check("t5_async_state", 32'(state),     32'd0);
    @(negedge clk);
    reset     = 1'b0;
    cipherRdy = 1'b0;
    clear_model();
    prev_cap = 1'b1; pulses = 0; low_cycles = 0;
    txReady = 1'b1;
    send_word("t5_cap_c", 16'hC3A5);
    run(5);
    check("t5_pulses", 32'(pulses), 32'd1);
    compare_stream("t5");

`ifdef PACKER_CSUM_EN
    // 6: two frames of two words each, checksum restarts per frame
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    prev_cap = 1'b1;
    txReady = 1'b1;
    send_word("t6_cap", 16'h1234);
    send_word("t6_cap", 16'h5678);
    send_word("t6_cap", 16'h1234);
    send_word("t6_cap", 16'h5678);
    run(10);
    exp.delete();
    exp.push_back(8'h12); exp.push_back(8'h34); exp.push_back(8'h56);
    exp.push_back(8'h78); exp.push_back(8'h08);
    exp.push_back(8'h12); exp.push_back(8'h34); exp.push_back(8'h56);
    exp.push_back(8'h78); exp.push_back(8'h08);
    compare_stream("t6");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
